// File: rtl/cpu_port_bridge_pkg.sv
// Shared constants and bus-slicing helper for the CPU port bridge.
package cpu_port_bridge_pkg;

  localparam int NUM_PORTS = 4;
  localparam int WORD_W    = 8;

  function automatic logic [WORD_W-1:0] lane_slice(
    input logic [NUM_PORTS*WORD_W-1:0] packed_bus,
    input int                          lane
  );
    return packed_bus[lane*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/cpu_port_bridge_if.sv
// CPU-side port signals and device-side valid/ready lanes of the bridge.
interface cpu_port_bridge_if;
  import cpu_port_bridge_pkg::*;

  logic [WORD_W-1:0]           out_port1, out_port2, out_port3, out_port4;
  logic [NUM_PORTS-1:0]        out_strobe;
  logic [WORD_W-1:0]           in_port1, in_port2, in_port3, in_port4;
  logic [NUM_PORTS-1:0]        in_strobe;
  logic [NUM_PORTS*WORD_W-1:0] tx_data;
  logic [NUM_PORTS-1:0]        tx_valid;
  logic [NUM_PORTS-1:0]        tx_ready;
  logic [NUM_PORTS*WORD_W-1:0] rx_data;
  logic [NUM_PORTS-1:0]        rx_valid;
  logic [NUM_PORTS-1:0]        rx_ready;
  logic [NUM_PORTS-1:0]        tx_ovf;
  logic [NUM_PORTS-1:0]        rx_udf;

  modport master (
    output out_port1, out_port2, out_port3, out_port4, out_strobe, in_strobe,
           tx_ready, rx_data, rx_valid,
    input  in_port1, in_port2, in_port3, in_port4, tx_data, tx_valid,
           rx_ready, tx_ovf, rx_udf
  );

  modport slave (
    input  out_port1, out_port2, out_port3, out_port4, out_strobe, in_strobe,
           tx_ready, rx_data, rx_valid,
    output in_port1, in_port2, in_port3, in_port4, tx_data, tx_valid,
           rx_ready, tx_ovf, rx_udf
  );

endinterface

// File: rtl/cpu_port_bridge_port_fifo.sv
// Byte-wide synchronous FIFO with head/next lookahead and over/underflow pulses.
module port_fifo
  import cpu_port_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WORD_W-1:0]        din,
  output logic [WORD_W-1:0]        dout,
  output logic [WORD_W-1:0]        dout_next,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  output logic                     udf
);
  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic              do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && !do_push;
  assign udf     = pop && empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout      = empty ? '0 : mem[rd_ptr];
  assign dout_next = (count >= (AW+1)'(2)) ? mem[rd_ptr + 1'b1] : '0;

endmodule

// File: rtl/cpu_port_bridge.sv
// Four-lane CPU I/O port bridge: per-lane TX and RX FIFOs, sticky error flags
// and the lookahead mux that feeds back-to-back CPU INPUTs.
module cpu_port_bridge
  import cpu_port_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  cpu_port_bridge_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0]           out_byte       [NUM_PORTS];
  logic [WORD_W-1:0]           in_byte        [NUM_PORTS];
  logic [WORD_W-1:0]           tx_head        [NUM_PORTS];
  logic [WORD_W-1:0]           rx_head        [NUM_PORTS];
  logic [WORD_W-1:0]           rx_next        [NUM_PORTS];
  logic [WORD_W-1:0]           unused_tx_next [NUM_PORTS];
  logic [CW-1:0]               unused_tx_count[NUM_PORTS];
  logic [CW-1:0]               unused_rx_count[NUM_PORTS];
  logic [NUM_PORTS-1:0]        tx_empty, tx_pop, tx_ovf_hit, unused_tx_full, unused_tx_udf;
  logic [NUM_PORTS-1:0]        rx_full, rx_udf_hit, unused_rx_empty, unused_rx_ovf;
  logic [NUM_PORTS*WORD_W-1:0] tx_bus;
  logic [NUM_PORTS-1:0]        tx_ovf_q, rx_udf_q;

  assign out_byte[0] = bus.out_port1;
  assign out_byte[1] = bus.out_port2;
  assign out_byte[2] = bus.out_port3;
  assign out_byte[3] = bus.out_port4;

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_lane
    assign tx_pop[n] = !tx_empty[n] && bus.tx_ready[n];

    port_fifo #(.DEPTH(DEPTH)) u_tx (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.out_strobe[n]),
      .pop       (tx_pop[n]),
      .din       (out_byte[n]),
      .dout      (tx_head[n]),
      .dout_next (unused_tx_next[n]),
      .count     (unused_tx_count[n]),
      .full      (unused_tx_full[n]),
      .empty     (tx_empty[n]),
      .ovf       (tx_ovf_hit[n]),
      .udf       (unused_tx_udf[n])
    );

    port_fifo #(.DEPTH(DEPTH)) u_rx (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.rx_valid[n] && !rx_full[n]),
      .pop       (bus.in_strobe[n]),
      .din       (lane_slice(bus.rx_data, n)),
      .dout      (rx_head[n]),
      .dout_next (rx_next[n]),
      .count     (unused_rx_count[n]),
      .full      (rx_full[n]),
      .empty     (unused_rx_empty[n]),
      .ovf       (unused_rx_ovf[n]),
      .udf       (rx_udf_hit[n])
    );

    assign tx_bus[n*WORD_W +: WORD_W] = tx_head[n];
    // While a read strobe is in flight the CPU is already sampling the following byte.
    assign in_byte[n] = bus.in_strobe[n] ? rx_next[n] : rx_head[n];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf_q <= '0;
      rx_udf_q <= '0;
    end else begin
      tx_ovf_q <= tx_ovf_q | tx_ovf_hit;
      rx_udf_q <= rx_udf_q | rx_udf_hit;
    end
  end

  assign bus.tx_data  = tx_bus;
  assign bus.tx_valid = ~tx_empty;
  assign bus.rx_ready = ~rx_full;
  assign bus.tx_ovf   = tx_ovf_q;
  assign bus.rx_udf   = rx_udf_q;
  assign bus.in_port1 = in_byte[0];
  assign bus.in_port2 = in_byte[1];
  assign bus.in_port3 = in_byte[2];
  assign bus.in_port4 = in_byte[3];

endmodule

// File: tb/tb_cpu_port_bridge.sv
// Directed and randomized bench for cpu_port_bridge against a queue-based model.
module tb_cpu_port_bridge;
  import cpu_port_bridge_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_port_bridge_if bus();

  cpu_port_bridge #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_q [4][$];
  logic [7:0] rx_q [4][$];
  logic [3:0] m_ovf, m_udf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare, then advance the model.
  task automatic step(input logic r, input logic [3:0] os, input logic [31:0] op,
                      input logic [3:0] is, input logic [3:0] tr,
                      input logic [3:0] rv, input logic [31:0] rd);
    logic [31:0] e_txd, e_in, g_in;
    logic [3:0]  e_txv, e_rxr;
    @(negedge clk);
    rst            = r;
    bus.out_strobe = os;
    bus.out_port1  = op[7:0];
    bus.out_port2  = op[15:8];
    bus.out_port3  = op[23:16];
    bus.out_port4  = op[31:24];
    bus.in_strobe  = is;
    bus.tx_ready   = tr;
    bus.rx_valid   = rv;
    bus.rx_data    = rd;
    #1;
    e_txd = '0;
    e_in  = '0;
    for (int n = 0; n < 4; n++) begin
      e_txv[n] = (tx_q[n].size() > 0);
      e_rxr[n] = (rx_q[n].size() < DEPTH);
      if (tx_q[n].size() > 0) e_txd[n*8 +: 8] = tx_q[n][0];
      if (is[n]) begin
        if (rx_q[n].size() >= 2) e_in[n*8 +: 8] = rx_q[n][1];
      end else begin
        if (rx_q[n].size() >= 1) e_in[n*8 +: 8] = rx_q[n][0];
      end
    end
    g_in = {bus.in_port4, bus.in_port3, bus.in_port2, bus.in_port1};
    chk("tx_valid", {28'd0, bus.tx_valid}, {28'd0, e_txv});
    chk("tx_data",  bus.tx_data, e_txd);
    chk("rx_ready", {28'd0, bus.rx_ready}, {28'd0, e_rxr});
    chk("in_port",  g_in, e_in);
    chk("tx_ovf",   {28'd0, bus.tx_ovf}, {28'd0, m_ovf});
    chk("rx_udf",   {28'd0, bus.rx_udf}, {28'd0, m_udf});
    if (r) begin
      for (int n = 0; n < 4; n++) begin
        tx_q[n].delete();
        rx_q[n].delete();
      end
      m_ovf = '0;
      m_udf = '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        bit tx_pop, rx_push;
        tx_pop  = (tx_q[n].size() > 0) && tr[n];
        rx_push = rv[n] && (rx_q[n].size() < DEPTH);
        if (os[n] && tx_q[n].size() == DEPTH && !tx_pop) m_ovf[n] = 1'b1;
        else begin
          if (tx_pop) void'(tx_q[n].pop_front());
          if (os[n])  tx_q[n].push_back(op[n*8 +: 8]);
        end
        if (is[n]) begin
          if (rx_q[n].size() == 0) m_udf[n] = 1'b1;
          else void'(rx_q[n].pop_front());
        end
        if (rx_push) rx_q[n].push_back(rd[n*8 +: 8]);
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 32'h0, 4'h0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 4'h0, 32'h0, 4'h0, 4'h0, 4'h0, 32'h0);
  endtask

  initial begin
    m_ovf = '0;
    m_udf = '0;
    rst = 1'b1;
    bus.out_strobe = '0; bus.in_strobe = '0; bus.tx_ready = '0; bus.rx_valid = '0;
    bus.rx_data = '0;
    bus.out_port1 = '0; bus.out_port2 = '0; bus.out_port3 = '0; bus.out_port4 = '0;
    repeat (2) @(posedge clk);

    // Reset state
    idle();
    chk("rst_rx_ready", {28'd0, bus.rx_ready}, 32'hF);
    chk("rst_tx_data", bus.tx_data, 32'h0);

    // TX ordering on port 2
    step(1'b0, 4'b0010, 32'h0000A100, 4'h0, 4'h0, 4'h0, 32'h0);
    chk("txo_valid_lat", {31'd0, bus.tx_valid[1]}, 32'd0);
    step(1'b0, 4'b0010, 32'h0000A200, 4'h0, 4'h0, 4'h0, 32'h0);
    chk("txo_valid_1", {31'd0, bus.tx_valid[1]}, 32'd1);
    step(1'b0, 4'b0010, 32'h0000A300, 4'h0, 4'h0, 4'h0, 32'h0);
    step(1'b0, 4'h0, 32'h0, 4'h0, 4'b0010, 4'h0, 32'h0);
    chk("txo_head_a1", {24'd0, bus.tx_data[15:8]}, 32'hA1);
    step(1'b0, 4'h0, 32'h0, 4'h0, 4'b0010, 4'h0, 32'h0);
    chk("txo_head_a2", {24'd0, bus.tx_data[15:8]}, 32'hA2);
    step(1'b0, 4'h0, 32'h0, 4'h0, 4'b0010, 4'h0, 32'h0);
    chk("txo_head_a3", {24'd0, bus.tx_data[15:8]}, 32'hA3);
    idle();
    chk("txo_drained", {31'd0, bus.tx_valid[1]}, 32'd0);

    // TX overflow, then a full-FIFO push that coincides with a pop
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b0, 4'b0001, i, 4'h0, 4'h0, 4'h0, 32'h0);
    idle();
    chk("ovf_flag", {28'd0, bus.tx_ovf}, 32'h1);
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b0, 4'b0001, i, 4'h0, 4'h0, 4'h0, 32'h0);
    step(1'b0, 4'b0001, 32'h5, 4'h0, 4'b0001, 4'h0, 32'h0);
    idle();
    chk("ovf_push_pop", {28'd0, bus.tx_ovf}, 32'h0);
    chk("ovf_push_pop_head", {24'd0, bus.tx_data[7:0]}, 32'h2);

    // RX lookahead on lane 3
    do_reset();
    step(1'b0, 4'h0, 32'h0, 4'h0, 4'h0, 4'b1000, 32'h11000000);
    step(1'b0, 4'h0, 32'h0, 4'h0, 4'h0, 4'b1000, 32'h22000000);
    idle();
    chk("la_head", {24'd0, bus.in_port4}, 32'h11);
    step(1'b0, 4'h0, 32'h0, 4'b1000, 4'h0, 4'h0, 32'h0);
    chk("la_pulse", {24'd0, bus.in_port4}, 32'h22);
    idle();
    chk("la_after", {24'd0, bus.in_port4}, 32'h22);
    step(1'b0, 4'h0, 32'h0, 4'b1000, 4'h0, 4'h0, 32'h0);
    chk("la_pulse2", {24'd0, bus.in_port4}, 32'h00);
    idle();
    chk("la_empty", {24'd0, bus.in_port4}, 32'h00);

    // RX underflow and full on lane 0
    do_reset();
    step(1'b0, 4'h0, 32'h0, 4'b0001, 4'h0, 4'h0, 32'h0);
    chk("udf_port", {24'd0, bus.in_port1}, 32'h00);
    idle();
    chk("udf_flag", {28'd0, bus.rx_udf}, 32'h1);
    for (int i = 1; i <= 4; i++) step(1'b0, 4'h0, 32'h0, 4'h0, 4'h0, 4'b0001, 32'h30 + i);
    idle();
    chk("rx_full", {31'd0, bus.rx_ready[0]}, 32'd0);
    step(1'b0, 4'h0, 32'h0, 4'h0, 4'h0, 4'b0001, 32'h99);
    idle();
    chk("rx_full_head", {24'd0, bus.in_port1}, 32'h31);

    // Reset with traffic queued
    step(1'b0, 4'b0001, 32'h5A, 4'b0010, 4'h0, 4'b0100, 32'h00770000);
    step(1'b0, 4'b0001, 32'h5B, 4'h0, 4'h0, 4'b0100, 32'h00780000);
    step(1'b0, 4'h0, 32'h0, 4'h0, 4'h0, 4'b0100, 32'h00790000);
    do_reset();
    idle();
    chk("mid_tx_valid", {28'd0, bus.tx_valid}, 32'h0);
    chk("mid_in_ports", {bus.in_port4, bus.in_port3, bus.in_port2, bus.in_port1}, 32'h0);
    chk("mid_flags", {24'd0, bus.tx_ovf, bus.rx_udf}, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), 4'($urandom), $urandom,
           4'($urandom & $urandom), 4'($urandom), 4'($urandom), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
